// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and operand bundle for serial_magnitude_comparator.
// The master issues start/operands; the slave (comparator) returns status and flags.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             g;
  logic             l;
  logic             e;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, g, l, e
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, g, l, e
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// MSB-first multi-cycle magnitude comparator, DIGIT bits per clock, unsigned or signed.
// Optional macro CMP_EARLY_EXIT_EN: leave RUN on the first unequal digit.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_magnitude_comparator_if.slave  cmp_if
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gen_bad_params
      $error("serial_magnitude_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               gt_q, gt_d;
  logic               lt_q, lt_d;
  logic               g_q, g_d;
  logic               l_q, l_d;
  logic               e_q, e_d;

  logic [DIGIT-1:0]   a_dig;
  logic [DIGIT-1:0]   b_dig;
  logic               dig_gt;
  logic               dig_lt;
  logic               gt_new;
  logic               lt_new;
  logic               last_dig;
  logic               run_exit;
  logic               accept;

  // Operands shift left each RUN cycle, so the current digit is always at the top.
  assign a_dig    = a_q[WIDTH-1 -: DIGIT];
  assign b_dig    = b_q[WIDTH-1 -: DIGIT];
  assign dig_gt   = (a_dig > b_dig);
  assign dig_lt   = (a_dig < b_dig);
  assign gt_new   = gt_q | (~lt_q & dig_gt);
  assign lt_new   = lt_q | (~gt_q & dig_lt);
  assign last_dig = (cnt_q == CNT_W'(N - 1));
  assign accept   = cmp_if.start && ((state_q == IDLE) || (state_q == DONE));

`ifdef CMP_EARLY_EXIT_EN
  assign run_exit = last_dig | dig_gt | dig_lt;
`else
  assign run_exit = last_dig;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    g_d     = g_q;
    l_d     = l_q;
    e_d     = e_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          a_d     = {cmp_if.a[WIDTH-1] ^ cmp_if.signed_mode, cmp_if.a[WIDTH-2:0]};
          b_d     = {cmp_if.b[WIDTH-1] ^ cmp_if.signed_mode, cmp_if.b[WIDTH-2:0]};
          cnt_d   = '0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          g_d     = 1'b0;
          l_d     = 1'b0;
          e_d     = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q << DIGIT;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q + 1'b1;
        gt_d  = gt_new;
        lt_d  = lt_new;
        if (run_exit) begin
          g_d     = gt_new;
          l_d     = lt_new;
          e_d     = ~gt_new & ~lt_new;
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      g_q     <= g_d;
      l_q     <= l_d;
      e_q     <= e_d;
    end
  end

  assign cmp_if.busy = (state_q == RUN);
  assign cmp_if.done = (state_q == DONE);
  assign cmp_if.g    = g_q;
  assign cmp_if.l    = l_q;
  assign cmp_if.e    = e_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=8, DIGIT=2).
// Timing expectations follow CMP_EARLY_EXIT_EN when it is defined.
module tb_serial_magnitude_comparator;

  localparam int W = 8;
  localparam int D = 2;
  localparam int N = W / D;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sm;
    logic         g;
    logic         l;
    logic         e;
    int           lat;
    int           acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  exp_t sb_q[$];

  serial_magnitude_comparator_if #(.WIDTH(W)) bus ();

  serial_magnitude_comparator #(
    .WIDTH (W),
    .DIGIT (D)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmp_if (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    exp_t r;
    int   k;
    bit   found;
    int   da, db;
    k     = N;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      da = int'(a >> (W - (i + 1) * D)) & ((1 << D) - 1);
      db = int'(b >> (W - (i + 1) * D)) & ((1 << D) - 1);
      if (!found && da != db) begin
        k     = i + 1;
        found = 1'b1;
      end
    end
    r.a  = a;
    r.b  = b;
    r.sm = sm;
    if (sm) begin
      r.g = ($signed(a) > $signed(b));
      r.l = ($signed(a) < $signed(b));
    end else begin
      r.g = (a > b);
      r.l = (a < b);
    end
    r.e = (a == b);
`ifdef CMP_EARLY_EXIT_EN
    r.lat = k;
`else
    r.lat = N;
`endif
    r.acc = 0;
    return r;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    exp_t r;
    r = model(a, b, sm);
    r.acc = cyc + 1;
    sb_q.push_back(r);
    bus.start       = 1'b1;
    bus.a           = a;
    bus.b           = b;
    bus.signed_mode = sm;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    issue_op(a, b, sm);
    step();
    bus.start       = 1'b0;
    bus.a           = W'($urandom);
    bus.b           = W'($urandom);
    bus.signed_mode = 1'($urandom);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    check("timeout_pending", sb_q.size(), 0);
    sb_q.delete();
    step();
  endtask

  // Monitor: scoreboard pops on done, plus per-cycle protocol invariants.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
      end else begin
        check("busy_done_excl", {31'd0, bus.busy & bus.done}, 0);
        check("flags_at_most_one", int'(bus.g) + int'(bus.l) + int'(bus.e) <= 1, 1);
        if (bus.busy) begin
          busy_cnt++;
          check("flags_clear_in_run", {29'd0, bus.g, bus.l, bus.e}, 0);
        end
        if (bus.done) begin
          check("done_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            check("g", {31'd0, bus.g}, {31'd0, x.g});
            check("l", {31'd0, bus.l}, {31'd0, x.l});
            check("e", {31'd0, bus.e}, {31'd0, x.e});
            check("latency", cyc - x.acc, x.lat);
            check("busy_cycles", busy_cnt, x.lat);
            $display("txn a=%h b=%h sm=%0d -> g=%0d l=%0d e=%0d lat=%0d (exp g=%0d l=%0d e=%0d lat=%0d)",
                     x.a, x.b, x.sm, bus.g, bus.l, bus.e, cyc - x.acc, x.g, x.l, x.e, x.lat);
          end
          busy_cnt = 0;
        end
      end
    end
  end

  initial begin
    int p;
    exp_t r;
    bus.start       = 1'b0;
    bus.a           = '0;
    bus.b           = '0;
    bus.signed_mode = 1'b0;

    repeat (3) step();
    check("rst_outputs", {27'd0, bus.busy, bus.done, bus.g, bus.l, bus.e}, 0);
    rst_n = 1'b1;
    step();

    // Directed cases including sign boundaries and early-exit timing.
    run_op(8'h5A, 8'h5A, 1'b0); wait_done();
    run_op(8'h80, 8'h7F, 1'b0); wait_done();
    run_op(8'h80, 8'h7F, 1'b1); wait_done();
    run_op(8'hFF, 8'h01, 1'b1); wait_done();
    run_op(8'hC0, 8'h00, 1'b0); wait_done();
    run_op(8'h7F, 8'h80, 1'b1); wait_done();
    run_op(8'h00, 8'hFF, 1'b0); wait_done();
    run_op(8'h00, 8'hFF, 1'b1); wait_done();
    run_op(8'h03, 8'h02, 1'b0); wait_done();

    for (int i = 0; i < 8; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
      wait_done();
    end

    // start pulsed mid-RUN must be ignored and produce no extra done.
    run_op(8'h33, 8'h33, 1'b0);
    step();
    bus.start       = 1'b1;
    bus.a           = 8'hFF;
    bus.b           = 8'h00;
    bus.signed_mode = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done();
    repeat (8) step();

    // Reset mid-RUN: outputs clear, no done, start right after release is accepted.
    run_op(8'h33, 8'h33, 1'b0);
    step();
    rst_n = 1'b0;
    sb_q.delete();
    step();
    check("midrun_rst_outputs", {27'd0, bus.busy, bus.done, bus.g, bus.l, bus.e}, 0);
    rst_n = 1'b1;
    issue_op(8'h01, 8'h02, 1'b0);
    step();
    bus.start = 1'b0;
    wait_done();
    repeat (8) step();

    // start held high: a new acceptance in every DONE cycle.
    r = model(8'h10, 8'h20, 1'b0);
    p = r.lat + 1;
    bus.start       = 1'b1;
    bus.a           = 8'h10;
    bus.b           = 8'h20;
    bus.signed_mode = 1'b0;
    for (int j = 0; j < 4; j++) begin
      r.acc = cyc + 1 + j * p;
      sb_q.push_back(r);
    end
    repeat (3 * p + 1) step();
    bus.start = 1'b0;
    wait_done();
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
